// File: rtl/aes_reg_writer.sv
// Streams DataWidth-bit words into a Width-word register bank, one write per accepted word.
// Handshake: a word transfers when in_valid_i && in_ready_o are both high on a rising clk_i edge.
module aes_reg_writer #(
  parameter int Width     = 16,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 in_ready_o,
  output logic [Width-1:0]     we_o,
  output logic [DataWidth-1:0] data_o,
  output logic [Width-1:0]     written_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int              PtrW    = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Width - 1);

  state_e               state_q, state_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [Width-1:0]     we_q, we_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [Width-1:0]     written_q, written_d;
  logic                 overflow_q, overflow_d;
  logic                 accept;

  // A clear blocks acceptance in the same cycle, so it always wins over in_valid_i.
  assign in_ready_o = (state_q != DONE) && !clear_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      we_q       <= '0;
      data_q     <= '0;
      written_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      data_q     <= data_d;
      written_q  <= written_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    we_d       = '0;
    data_d     = data_q;
    written_d  = written_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      state_d    = IDLE;
      ptr_d      = '0;
      written_d  = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            we_d      = Width'(1) << ptr_q;
            data_d    = in_data_i;
            written_d = written_q | (Width'(1) << ptr_q);
            if (ptr_q == LastPtr) begin
              state_d = DONE;
              ptr_d   = '0;
            end else begin
              state_d = LOAD;
              ptr_d   = ptr_q + 1'b1;
            end
          end
        end
        DONE: begin
          // Words offered after completion are dropped but remembered as an overflow.
          if (in_valid_i) begin
            overflow_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign we_o       = we_q;
  assign data_o     = data_q;
  assign written_o  = written_q;
  assign overflow_o = overflow_q;
  assign done_o     = (state_q == DONE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_aes_reg_writer.sv
// Directed bench for aes_reg_writer: a Width=16 instance driven from a vector table plus
// hand-written reset and Width=1 sequences.
module tb_aes_reg_writer;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic [15:0] we;
  logic [31:0] dout;
  logic [15:0] written;
  logic        done;
  logic        ovf;
  logic [1:0]  state;

  logic        clear1;
  logic        valid1;
  logic [31:0] data1;
  logic        ready1;
  logic [0:0]  we1;
  logic [31:0] dout1;
  logic [0:0]  written1;
  logic        done1;
  logic        ovf1;
  logic [1:0]  state1;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct {
    logic        valid;
    logic        clear;
    logic [31:0] data;
    logic        exp_ready;
    logic [15:0] exp_we;
    logic [31:0] exp_data;
    logic [15:0] exp_written;
    logic        exp_done;
    logic        exp_ovf;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];

  aes_reg_writer #(.Width(16), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(valid), .in_data_i(data),
    .in_ready_o(ready), .we_o(we), .data_o(dout), .written_o(written), .done_o(done),
    .overflow_o(ovf), .state_o(state)
  );

  aes_reg_writer #(.Width(1), .DataWidth(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear1), .in_valid_i(valid1), .in_data_i(data1),
    .in_ready_o(ready1), .we_o(we1), .data_o(dout1), .written_o(written1), .done_o(done1),
    .overflow_o(ovf1), .state_o(state1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic c, input logic [31:0] d,
                              input logic rdy, input logic [15:0] w, input logic [31:0] dexp,
                              input logic [15:0] wr, input logic dn, input logic ov,
                              input logic [1:0] st);
    vec_t r;
    r.valid = v; r.clear = c; r.data = d; r.exp_ready = rdy; r.exp_we = w;
    r.exp_data = dexp; r.exp_written = wr; r.exp_done = dn; r.exp_ovf = ov; r.exp_state = st;
    return r;
  endfunction

  // Driver: called just after a rising edge; one call spans exactly one clock cycle.
  task automatic apply(input vec_t v, input string tag);
    valid = v.valid;
    clear = v.clear;
    data  = v.data;
    #2;
    chk({tag, "_ready"}, 64'(ready), 64'(v.exp_ready));
    @(posedge clk);
    #1;
    chk({tag, "_we"}, 64'(we), 64'(v.exp_we));
    chk({tag, "_data"}, 64'(dout), 64'(v.exp_data));
    chk({tag, "_written"}, 64'(written), 64'(v.exp_written));
    chk({tag, "_done"}, 64'(done), 64'(v.exp_done));
    chk({tag, "_ovf"}, 64'(ovf), 64'(v.exp_ovf));
    chk({tag, "_state"}, 64'(state), 64'(v.exp_state));
    valid = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] full_mask;

    // Full load of 16 words, we_o walks one bit per accept.
    for (int i = 0; i < 16; i++) begin
      full_mask = (32'd2 << i) - 32'd1;
      vecs.push_back(mk(1'b1, 1'b0, 32'h1000 + 32'(i), 1'b1, 16'(32'd1 << i), 32'h1000 + 32'(i),
                        full_mask[15:0], (i == 15), 1'b0, (i == 15) ? S_DONE : S_LOAD));
    end
    // Word offered in DONE: refused, sticky overflow.
    vecs.push_back(mk(1'b1, 1'b0, 32'hDEAD, 1'b0, 16'h0000, 32'h100F, 16'hFFFF, 1'b1, 1'b1, S_DONE));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 16'h0000, 32'h100F, 16'hFFFF, 1'b1, 1'b1, S_DONE));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0, 1'b0, 16'h0000, 32'h100F, 16'h0000, 1'b0, 1'b0, S_IDLE));
    // Gapped traffic: valid toggles 1/0 for four words.
    vecs.push_back(mk(1'b1, 1'b0, 32'h2000, 1'b1, 16'h0001, 32'h2000, 16'h0001, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 16'h0000, 32'h2000, 16'h0001, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b1, 1'b0, 32'h2001, 1'b1, 16'h0002, 32'h2001, 16'h0003, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 16'h0000, 32'h2001, 16'h0003, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b1, 1'b0, 32'h2002, 1'b1, 16'h0004, 32'h2002, 16'h0007, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 16'h0000, 32'h2002, 16'h0007, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b1, 1'b0, 32'h2003, 1'b1, 16'h0008, 32'h2003, 16'h000F, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 16'h0000, 32'h2003, 16'h000F, 1'b0, 1'b0, S_LOAD));
    // Fifth word, then clear together with valid: no accept, restart at word 0.
    vecs.push_back(mk(1'b1, 1'b0, 32'h2004, 1'b1, 16'h0010, 32'h2004, 16'h001F, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b1, 1'b1, 32'h2BAD, 1'b0, 16'h0000, 32'h2004, 16'h0000, 1'b0, 1'b0, S_IDLE));
    vecs.push_back(mk(1'b1, 1'b0, 32'h3000, 1'b1, 16'h0001, 32'h3000, 16'h0001, 1'b0, 1'b0, S_LOAD));
    // Accept followed by a clear: the pulse of the accept stands, the clear wipes progress.
    vecs.push_back(mk(1'b1, 1'b0, 32'h3001, 1'b1, 16'h0002, 32'h3001, 16'h0003, 1'b0, 1'b0, S_LOAD));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0, 1'b0, 16'h0000, 32'h3001, 16'h0000, 1'b0, 1'b0, S_IDLE));

    rst = 1'b1; clear = 1'b0; valid = 1'b0; data = '0;
    clear1 = 1'b0; valid1 = 1'b0; data1 = '0;
    #1;
    chk("rst_we", 64'(we), 64'h0);
    chk("rst_data", 64'(dout), 64'h0);
    chk("rst_written", 64'(written), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_state", 64'(state), 64'(S_IDLE));
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // Width = 1: one accept completes the bank in the same cycle as its pulse.
    valid1 = 1'b1; data1 = 32'hA5A5A5A5;
    #2;
    chk("w1_ready", 64'(ready1), 64'h1);
    @(posedge clk); #1;
    chk("w1_we", 64'(we1), 64'h1);
    chk("w1_data", 64'(dout1), 64'hA5A5A5A5);
    chk("w1_done", 64'(done1), 64'h1);
    chk("w1_written", 64'(written1), 64'h1);
    chk("w1_state", 64'(state1), 64'(S_DONE));
    data1 = 32'h5A5A5A5A;
    #2;
    chk("w1_ready_done", 64'(ready1), 64'h0);
    @(posedge clk); #1;
    chk("w1_we_done", 64'(we1), 64'h0);
    chk("w1_ovf", 64'(ovf1), 64'h1);
    chk("w1_data_hold", 64'(dout1), 64'hA5A5A5A5);
    valid1 = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

    // Seven words, then an asynchronous reset in the middle of the cycle.
    for (int i = 0; i < 7; i++) begin
      full_mask = (32'd2 << i) - 32'd1;
      apply(mk(1'b1, 1'b0, 32'h4000 + 32'(i), 1'b1, 16'(32'd1 << i), 32'h4000 + 32'(i),
               full_mask[15:0], 1'b0, 1'b0, S_LOAD), $sformatf("pre_rst%0d", i));
    end
    #3;
    rst = 1'b1;
    #1;
    chk("arst_we", 64'(we), 64'h0);
    chk("arst_data", 64'(dout), 64'h0);
    chk("arst_written", 64'(written), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    chk("arst_ovf", 64'(ovf), 64'h0);
    chk("arst_state", 64'(state), 64'(S_IDLE));
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    apply(mk(1'b1, 1'b0, 32'h5000, 1'b1, 16'h0001, 32'h5000, 16'h0001, 1'b0, 1'b0, S_LOAD),
          "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_reg_writer.md
AES_REG_WRITER -- requirements
Module: aes_reg_writer

Interface
REQ-001 SHALL have parameter Width, default 16, meaning the number of register words in the target bank (Width >= 1).
REQ-002 SHALL have parameter DataWidth, default 32, meaning the bits per register word.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous abort/restart request.
REQ-006 SHALL have port in_valid_i, input, 1 bit: the upstream word is valid.
REQ-007 SHALL have port in_data_i, input, DataWidth bits: the upstream word.
REQ-008 SHALL have port in_ready_o, output, 1 bit: the block can accept a word this cycle.
REQ-009 SHALL have port we_o, output, Width bits: one-hot per-word write enable into the register bank.
REQ-010 SHALL have port data_o, output, DataWidth bits: write data accompanying we_o.
REQ-011 SHALL have port written_o, output, Width bits: mask of words written since the last clear.
REQ-012 SHALL have port done_o, output, 1 bit: all Width words have been written.
REQ-013 SHALL have port overflow_o, output, 1 bit: sticky flag for a word offered after completion.

Function
REQ-014 SHALL implement an FSM with states IDLE, LOAD and DONE.
REQ-015 SHALL hold an internal word pointer ptr, clog2(Width) bits wide (minimum 1 bit).
REQ-016 SHALL drive in_ready_o = (state != DONE) && !clear_i, combinationally.
REQ-017 SHALL define an accept as in_valid_i && in_ready_o; on an accept, the next cycle SHALL present we_o = (1 << ptr) and data_o = in_data_i, both registered (latency 1 cycle).
REQ-018 SHALL keep we_o at zero in every cycle that does not follow an accept; we_o SHALL never have more than one bit set.
REQ-019 SHALL leave data_o unchanged when there is no accept.
REQ-020 SHALL, on an accept, set written_o[ptr] and increment ptr.
REQ-021 SHALL, on an accept with ptr == Width-1, move to DONE and wrap ptr to 0.
REQ-022 SHALL make the transitions IDLE->LOAD on the first accept (IDLE->DONE directly when Width == 1), and LOAD->DONE per REQ-021.
REQ-023 SHALL drive done_o = 1 exactly while in DONE; done_o SHALL assert in the same cycle as the final we_o pulse.
REQ-024 SHALL, in DONE, ignore in_valid_i and set overflow_o sticky high if in_valid_i == 1.
REQ-025 SHALL, on clear_i == 1 in any state, return to IDLE next cycle with ptr = 0, written_o = 0, overflow_o = 0 and we_o = 0.
REQ-026 SHALL give clear_i priority over a simultaneous in_valid_i (no accept occurs, per REQ-016).
REQ-027 SHALL give a pending we_o pulse no precedence over clear_i; a clear in the cycle after an accept still lets that cycle's we_o pulse stand.
REQ-028 SHALL apply written_o bit updates using bitwise OR only; bits SHALL never clear except on clear_i or reset.

Reset
REQ-029 SHALL, while rst_i is high, asynchronously force: state = IDLE, ptr = 0, we_o = 0, data_o = 0, written_o = 0, done_o = 0, overflow_o = 0.
REQ-030 SHALL, when reset is asserted mid-LOAD, discard all progress; after release, the next accept SHALL target word 0.

Verification
REQ-031 SHALL verify a full load: Width = 16, 16 back-to-back accepts of 0x1000+i -> we_o walks 0x0001..0x8000 one cycle after each accept, data_o = 0x1000+i, done_o = 1 and written_o = 0xFFFF after the 16th pulse.
REQ-032 SHALL verify gaps: in_valid_i toggled 1/0 for 4 words -> exactly 4 we_o pulses (bits 0..3), written_o = 0x000F, state = LOAD, done_o = 0.
REQ-033 SHALL verify overflow: in DONE, in_valid_i = 1 with data 0xDEAD -> in_ready_o = 0, no we_o pulse, overflow_o = 1 until clear_i.
REQ-034 SHALL verify clear priority: after 5 words, clear_i = 1 together with in_valid_i = 1 -> no accept, next cycle written_o = 0, state = IDLE, and the next accept writes we_o = 0x0001.
REQ-035 SHALL verify async reset: rst_i pulsed mid-cycle after 7 words -> all outputs 0 immediately without waiting for a clock edge; the next accept writes word 0.
REQ-036 SHALL verify Width = 1: a single accept of 0xA5A5A5A5 -> we_o = 1, data_o = 0xA5A5A5A5, done_o = 1 in the same cycle.
